// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: parametrised count/width, per-register RO mode, byte strobes, SLVERR.
// Optional write-one-to-clear registers with hardware set inputs when AXI_REGBANK_W1C_EN is defined.
module axi_lite_regbank #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
    parameter int unsigned C_NUM_REGS         = 16,
    parameter logic [C_NUM_REGS-1:0] C_RO_MASK = '0
`ifdef AXI_REGBANK_W1C_EN
    ,
    parameter logic [C_NUM_REGS-1:0] C_W1C_MASK = '0
`endif
) (
    input  logic                                     S_AXI_ACLK,
    input  logic                                     S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                               S_AXI_AWPROT,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                               S_AXI_ARPROT,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
    output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_status,
    output logic [C_NUM_REGS-1:0]                    wr_pulse
`ifdef AXI_REGBANK_W1C_EN
    ,
    input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_set
`endif
);

    localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
    localparam int unsigned ADDR_W = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned NB     = DW / 8;
    localparam int unsigned LSB    = $clog2(NB);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

`ifdef AXI_REGBANK_W1C_EN
    localparam logic [C_NUM_REGS-1:0] W1C = C_W1C_MASK;
`else
    localparam logic [C_NUM_REGS-1:0] W1C = '0;
`endif
    localparam logic [C_NUM_REGS-1:0] RO = C_RO_MASK & ~W1C;

    logic                  ready_en;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_W-1:0]     aw_addr;
    logic [DW-1:0]         w_data;
    logic [NB-1:0]         w_strb;
    logic                  bvalid;
    logic [1:0]            bresp;
    logic                  rvalid;
    logic [1:0]            rresp;
    logic [DW-1:0]         rdata;
    logic [C_NUM_REGS-1:0] pulse;

    logic [DW-1:0]         regs      [C_NUM_REGS];
    logic [DW-1:0]         regs_next [C_NUM_REGS];

    logic [ADDR_W-1:0]     wr_idx;
    logic [ADDR_W-1:0]     rd_idx;
    logic [C_NUM_REGS-1:0] wr_sel;
    logic [C_NUM_REGS-1:0] rd_sel;
    logic                  commit;
    logic                  wr_ok;
    logic [DW-1:0]         byte_mask;
    logic [DW-1:0]         rd_word;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  ar_fire;

    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // ready_en keeps every READY low while in reset and for the first edge after it
    assign S_AXI_AWREADY = ready_en & ~aw_held & ~bvalid;
    assign S_AXI_WREADY  = ready_en & ~w_held & ~bvalid;
    assign S_AXI_ARREADY = ready_en & ~rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RDATA   = rdata;
    assign wr_pulse      = pulse;

    assign aw_fire = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_fire  = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_fire = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit  = aw_held & w_held;

    // Full-width word index compare: nonzero upper bits can never match any register
    always_comb begin
        wr_idx = aw_addr >> LSB;
        rd_idx = S_AXI_ARADDR >> LSB;
        wr_sel = '0;
        rd_sel = '0;
        for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
            wr_sel[i] = (wr_idx == ADDR_W'(i));
            rd_sel[i] = (rd_idx == ADDR_W'(i));
        end
        wr_ok = |(wr_sel & ~RO);
    end

    always_comb begin
        byte_mask = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            byte_mask[b*8 +: 8] = {8{w_strb[b]}};
        end
    end

    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
            if (rd_sel[i]) begin
                rd_word = RO[i] ? hw_status[i*DW +: DW] : regs[i];
            end
        end
    end

    // Hardware set is applied after the AXI clear so a same-cycle set wins
    always_comb begin
        for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
            regs_next[i] = regs[i];
            if (commit && wr_sel[i] && !RO[i]) begin
                if (W1C[i]) begin
                    regs_next[i] = regs[i] & ~(w_data & byte_mask);
                end else begin
                    regs_next[i] = (regs[i] & ~byte_mask) | (w_data & byte_mask);
                end
            end
`ifdef AXI_REGBANK_W1C_EN
            if (W1C[i]) begin
                regs_next[i] = regs_next[i] | hw_set[i*DW +: DW];
            end
`endif
            if (RO[i]) begin
                regs_next[i] = '0;
            end
        end
    end

    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
            reg_out[i*DW +: DW] = regs[i];
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ready_en <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            rvalid   <= 1'b0;
            rresp    <= RESP_OKAY;
            rdata    <= '0;
            pulse    <= '0;
            for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            ready_en <= 1'b1;
            pulse    <= '0;
            if (aw_fire) begin
                aw_held <= 1'b1;
                aw_addr <= S_AXI_AWADDR;
            end
            if (w_fire) begin
                w_held <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                pulse   <= wr_sel & ~RO;
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
            if (ar_fire) begin
                rvalid <= 1'b1;
                rdata  <= rd_word;
                rresp  <= (|rd_sel) ? RESP_OKAY : RESP_SLVERR;
            end else if (rvalid && S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
            for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
                regs[i] <= regs_next[i];
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Bench for axi_lite_regbank: vector table plus response scoreboard and hand-written timing sequences.
`timescale 1ns/1ps
module tb_axi_lite_regbank;

    localparam int NR = 16;
    localparam int DW = 32;
    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;
`ifdef AXI_REGBANK_W1C_EN
    localparam logic [31:0] REG0_EXP = 32'h0;
`else
    localparam logic [31:0] REG0_EXP = 32'h1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [NR*DW-1:0] reg_out, hw_status;
    logic [NR-1:0]    wr_pulse;
`ifdef AXI_REGBANK_W1C_EN
    logic [NR*DW-1:0] hw_set;
`endif

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    vec_t       vecs[$];
    logic [1:0] bq[$];
    rexp_t      rq[$];
    logic [1:0] be;
    rexp_t      re;
    int         pulse_cnt[NR];
    int         exp_cnt[NR];
    int         n_vec = 0;
    int         n_bad = 0;

    axi_lite_regbank #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(8),
        .C_NUM_REGS(16),
        .C_RO_MASK(16'h0002)
`ifdef AXI_REGBANK_W1C_EN
        ,
        .C_W1C_MASK(16'h0001)
`endif
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr),
        .S_AXI_AWPROT(awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),
        .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),
        .S_AXI_ARPROT(arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),
        .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready),
        .reg_out(reg_out),
        .hw_status(hw_status),
        .wr_pulse(wr_pulse)
`ifdef AXI_REGBANK_W1C_EN
        ,
        .hw_set(hw_set)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: responses are compared when the handshake completes
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NR; i++) begin
                if (wr_pulse[i]) pulse_cnt[i]++;
            end
            if (wr_pulse != '0) check("pulse_with_bvalid", 64'(bvalid), 64'd1);
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    check("b_unexpected", 64'(bvalid), 64'd0);
                end else begin
                    be = bq.pop_front();
                    check("bresp", 64'(bresp), 64'(be));
                end
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    check("r_unexpected", 64'(rvalid), 64'd0);
                end else begin
                    re = rq.pop_front();
                    check("rdata", 64'(rdata), 64'(re.data));
                    check("rresp", 64'(rresp), 64'(re.resp));
                end
            end
        end
    end

    task automatic wait_b();
        int n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            done = bvalid && bready;
            n++;
        end
        if (!done) check("b_timeout", 64'(done), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_r();
        int n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            done = rvalid && rready;
            n++;
        end
        if (!done) check("r_timeout", 64'(done), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic write_txn(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] exp);
        int n;
        logic awf, wf;
        bq.push_back(exp);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            @(negedge clk);
            awf = awvalid && awready;
            wf  = wvalid && wready;
            @(posedge clk); #1;
            if (awf) awvalid = 1'b0;
            if (wf)  wvalid = 1'b0;
            n++;
        end
        if (awvalid || wvalid) begin
            check("write_accept_timeout", 64'({awvalid, wvalid}), 64'd0);
            awvalid = 1'b0; wvalid = 1'b0;
        end
        wait_b();
    endtask

    task automatic read_txn(input logic [7:0] a, input logic [31:0] d, input logic [1:0] r);
        int n;
        logic arf;
        rq.push_back(rexp_t'{d, r});
        araddr = a;
        arvalid = 1'b1;
        n = 0;
        while (arvalid && n < 20) begin
            @(negedge clk);
            arf = arvalid && arready;
            @(posedge clk); #1;
            if (arf) arvalid = 1'b0;
            n++;
        end
        if (arvalid) begin
            check("read_accept_timeout", 64'(arvalid), 64'd0);
            arvalid = 1'b0;
        end
        wait_r();
    endtask

    // Called just after the edge where the last of AW/W was accepted
    task automatic expect_b_next(input logic [NR-1:0] exp_pulse);
        @(negedge clk);
        check("b_latency_commit_cycle", 64'(bvalid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("b_latency", 64'(bvalid), 64'd1);
        check("b_pulse", 64'(wr_pulse), 64'(exp_pulse));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        wdata = '0; wstrb = '0;
        hw_status = {NR{32'hC0DE0000}};
        hw_status[63:32] = 32'hDEADBEEF;
`ifdef AXI_REGBANK_W1C_EN
        hw_set = '0;
`endif
        exp_cnt = '{1, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

        vecs.push_back(vec_t'{1'b1, 8'h00, 32'h00000001, 4'hF, 32'h0, OK});
        vecs.push_back(vec_t'{1'b1, 8'h08, 32'h00000002, 4'hF, 32'h0, OK});
        vecs.push_back(vec_t'{1'b1, 8'h0C, 32'h00000003, 4'hF, 32'h0, OK});
        vecs.push_back(vec_t'{1'b1, 8'h10, 32'h00000004, 4'hF, 32'h0, OK});
        vecs.push_back(vec_t'{1'b0, 8'h00, 32'h0, 4'h0, REG0_EXP, OK});
        vecs.push_back(vec_t'{1'b0, 8'h08, 32'h0, 4'h0, 32'h00000002, OK});
        vecs.push_back(vec_t'{1'b0, 8'h0C, 32'h0, 4'h0, 32'h00000003, OK});
        vecs.push_back(vec_t'{1'b0, 8'h10, 32'h0, 4'h0, 32'h00000004, OK});
        vecs.push_back(vec_t'{1'b1, 8'h08, 32'hAABBCCDD, 4'hF, 32'h0, OK});
        vecs.push_back(vec_t'{1'b1, 8'h08, 32'h11223344, 4'h5, 32'h0, OK});
        vecs.push_back(vec_t'{1'b0, 8'h08, 32'h0, 4'h0, 32'hAA22CC44, OK});
        vecs.push_back(vec_t'{1'b1, 8'h08, 32'hFFFFFFFF, 4'h0, 32'h0, OK});
        vecs.push_back(vec_t'{1'b0, 8'h08, 32'h0, 4'h0, 32'hAA22CC44, OK});
        vecs.push_back(vec_t'{1'b1, 8'h04, 32'h00000005, 4'hF, 32'h0, ERR});
        vecs.push_back(vec_t'{1'b0, 8'h04, 32'h0, 4'h0, 32'hDEADBEEF, OK});
        vecs.push_back(vec_t'{1'b0, 8'h40, 32'h0, 4'h0, 32'h0, ERR});
        vecs.push_back(vec_t'{1'b1, 8'h40, 32'h00000001, 4'hF, 32'h0, ERR});
        vecs.push_back(vec_t'{1'b0, 8'h80, 32'h0, 4'h0, 32'h0, ERR});
        vecs.push_back(vec_t'{1'b0, 8'h02, 32'h0, 4'h0, REG0_EXP, OK});
        vecs.push_back(vec_t'{1'b1, 8'h3C, 32'h12345678, 4'hF, 32'h0, OK});
        vecs.push_back(vec_t'{1'b0, 8'h3C, 32'h0, 4'h0, 32'h12345678, OK});
        vecs.push_back(vec_t'{1'b0, 8'h30, 32'h0, 4'h0, 32'h0, OK});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_handshake", 64'({awready, wready, bvalid, arready, rvalid}), 64'd0);
        check("reset_resp_data", 64'({bresp, rresp, rdata}), 64'd0);
        check("reset_pulse", 64'(wr_pulse), 64'd0);
        check("reset_reg_out", 64'(|reg_out), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) write_txn(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
            else            read_txn(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
        end
        for (int i = 0; i < NR; i++) check($sformatf("pulse_cnt_%0d", i), 64'(pulse_cnt[i]), 64'(exp_cnt[i]));
        check("reg_out_0", 64'(reg_out[31:0]), 64'(REG0_EXP));
        check("reg_out_2", 64'(reg_out[95:64]), 64'h00000000AA22CC44);

        // W three cycles ahead of AW
        bq.push_back(OK);
        wdata = 32'hA5A50005; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        check("w_first_ready", 64'(wready), 64'd1);
        @(posedge clk); #1;
        wvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("w_held_wready", 64'(wready), 64'd0);
            check("w_held_no_b", 64'(bvalid), 64'd0);
            @(posedge clk); #1;
        end
        awaddr = 8'h14; awvalid = 1'b1;
        @(negedge clk);
        check("aw_late_ready", 64'(awready), 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        expect_b_next(16'h0020);

        // AW and W in the same cycle
        bq.push_back(OK);
        awaddr = 8'h18; wdata = 32'h00000066; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        check("same_cycle_ready", 64'({awready, wready}), 64'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        expect_b_next(16'h0040);
        check("pulse_cnt_5_once", 64'(pulse_cnt[5]), 64'd1);
        check("pulse_cnt_6_once", 64'(pulse_cnt[6]), 64'd1);
        read_txn(8'h14, 32'hA5A50005, OK);
        read_txn(8'h18, 32'h00000066, OK);

        // B back-pressure
        bready = 1'b0;
        bq.push_back(OK);
        awaddr = 8'h1C; wdata = 32'h00000077; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        repeat (5) begin
            @(negedge clk);
            check("bstall_bvalid", 64'(bvalid), 64'd1);
            check("bstall_bresp", 64'(bresp), 64'(OK));
            check("bstall_ready", 64'({awready, wready}), 64'd0);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("awready_after_b", 64'(awready), 64'd1);
        @(posedge clk); #1;

        // R back-pressure; RO value is captured at the AR edge
        rready = 1'b0;
        rq.push_back(rexp_t'{32'hDEADBEEF, OK});
        araddr = 8'h04; arvalid = 1'b1;
        @(negedge clk);
        check("rstall_arready", 64'(arready), 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        hw_status[63:32] = 32'h12345678;
        repeat (5) begin
            @(negedge clk);
            check("rstall_rvalid", 64'(rvalid), 64'd1);
            check("rstall_rdata", 64'(rdata), 64'h00000000DEADBEEF);
            check("rstall_arready_low", 64'(arready), 64'd0);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("arready_after_r", 64'(arready), 64'd1);
        @(posedge clk); #1;

        // Reset with AW latched and W pending
        awaddr = 8'h20; awvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        awvalid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midreset_handshake", 64'({awready, wready, bvalid, arready, rvalid}), 64'd0);
        check("midreset_resp_data", 64'({bresp, rresp, rdata}), 64'd0);
        check("midreset_reg_out", 64'(|reg_out), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        read_txn(8'h1C, 32'h0, OK);
        wdata = 32'h00000088; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        wvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_b_after_reset", 64'(bvalid), 64'd0);
            @(posedge clk); #1;
        end
        read_txn(8'h20, 32'h0, OK);
        bq.push_back(OK);
        awaddr = 8'h20; awvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        awvalid = 1'b0;
        expect_b_next(16'h0100);
        read_txn(8'h20, 32'h00000088, OK);

`ifdef AXI_REGBANK_W1C_EN
        hw_set[31:0] = 32'h0000000F;
        @(posedge clk); #1;
        hw_set = '0;
        read_txn(8'h00, 32'h0000000F, OK);
        write_txn(8'h00, 32'h00000005, 4'hF, OK);
        read_txn(8'h00, 32'h0000000A, OK);
`endif

        repeat (2) @(posedge clk);
        check("bq_drained", 64'(bq.size()), 64'd0);
        check("rq_drained", 64'(rq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
